// File: rtl/spi_dds_ctrl.sv
// SPI slave register block feeding the DDS compiler tuning-word port (data/we) in the clk domain.
// Optional readback path enabled by defining SPI_READBACK_EN.
module spi_dds_ctrl #(
    parameter int unsigned      FTW_W     = 48,
    parameter logic [FTW_W-1:0] FTW_RESET = 48'h0000218DEF41,
    parameter logic [FTW_W-1:0] ID_VALUE  = 48'h00000E7C0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCK,
    input  logic             MOSI,
    input  logic             SSEL,
    output logic             MISO,
    output logic [FTW_W-1:0] dds_data,
    output logic             dds_we,
    output logic             out_en,
    output logic             frame_err
);

    localparam int unsigned FRAME_BITS = FTW_W + 8;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [2:0]       r_sck_s;
    logic [2:0]       r_ssel_s;
    logic [1:0]       r_mosi_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [FTW_W-1:0] r_rx_sr;
    logic             r_cmd_rd;
    logic [1:0]       r_cmd_addr;
    logic             r_exec;
    logic [FTW_W-1:0] r_stage;
    logic [FTW_W-1:0] r_dds_data;
    logic             r_dds_we;
    logic             r_out_en;
    logic             r_auto;
    logic             r_err;

    logic             w_sck_rise;
    logic             w_ssel_rise;
    logic             w_ssel_fall;
    logic             w_ssel_hi;
    logic             w_mosi;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_shift_in;
    logic             w_cmd_done;
    logic             w_frame_done;
    logic             w_abort;

    // The SSEL synchroniser resets to "selected" so a frame already in progress at reset
    // release never produces a falling edge; that frame is ignored until SSEL goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_s  <= 3'b000;
            r_ssel_s <= 3'b000;
            r_mosi_s <= 2'b00;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], SCK};
            r_ssel_s <= {r_ssel_s[1:0], SSEL};
            r_mosi_s <= {r_mosi_s[0], MOSI};
        end
    end

    assign w_sck_rise  = r_sck_s[1] & ~r_sck_s[2];
    assign w_ssel_rise = r_ssel_s[1] & ~r_ssel_s[2];
    assign w_ssel_fall = ~r_ssel_s[1] & r_ssel_s[2];
    assign w_ssel_hi   = r_ssel_s[1];
    assign w_mosi      = r_mosi_s[1];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = w_ssel_hi ? '0 : r_cnt;
        w_shift_in   = 1'b0;
        w_cmd_done   = 1'b0;
        w_frame_done = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ssel_fall) w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (w_ssel_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (w_sck_rise) begin
                    w_shift_in = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(7)) begin
                        w_state_nxt = ST_DATA;
                        w_cmd_done  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_ssel_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (w_sck_rise) begin
                    w_shift_in = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
                        w_state_nxt  = ST_DONE;
                        w_frame_done = 1'b1;
                    end
                end
            end
            default: begin
                if (w_ssel_rise) w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rx_sr    <= '0;
            r_cmd_rd   <= 1'b0;
            r_cmd_addr <= 2'd0;
            r_exec     <= 1'b0;
            r_stage    <= FTW_RESET;
            r_dds_data <= FTW_RESET;
            r_dds_we   <= 1'b0;
            r_out_en   <= 1'b0;
            r_auto     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dds_we <= 1'b0;
            r_exec   <= w_frame_done & ~r_cmd_rd;
            if (w_shift_in) r_rx_sr <= {r_rx_sr[FTW_W-2:0], w_mosi};
            if (w_cmd_done) begin
                r_cmd_rd   <= r_rx_sr[6];
                r_cmd_addr <= {r_rx_sr[0], w_mosi};
            end
            if (w_abort) r_err <= 1'b1;
            if (r_exec) begin
                case (r_cmd_addr)
                    2'd0: begin
                        r_stage <= r_rx_sr;
                        if (r_auto) begin
                            r_dds_data <= r_rx_sr;
                            r_dds_we   <= 1'b1;
                        end
                    end
                    2'd1: begin
                        r_out_en <= r_rx_sr[0];
                        r_auto   <= r_rx_sr[1];
                        if (r_rx_sr[7]) r_err <= 1'b0;
                    end
                    2'd2: begin
                        r_dds_data <= r_stage;
                        r_dds_we   <= 1'b1;
                    end
                    default: r_err <= 1'b1;
                endcase
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic [FTW_W-1:0] r_tx_sr;
    logic [FTW_W-1:0] w_rd_data;
    logic [1:0]       w_ld_addr;
    logic             w_sck_fall;
    logic             w_tx_act;

    assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
    assign w_ld_addr  = {r_rx_sr[0], w_mosi};
    assign w_tx_act   = (r_state == ST_DATA) || (r_state == ST_DONE);

    always_comb begin
        w_rd_data = '0;
        case (w_ld_addr)
            2'd0:    w_rd_data = r_stage;
            2'd1:    w_rd_data = {{(FTW_W-2){1'b0}}, r_auto, r_out_en};
            2'd2:    w_rd_data = '0;
            default: w_rd_data = ID_VALUE;
        endcase
    end

    // The fall right after the 8th rise is skipped so bit 47 is still valid at the 9th rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sr <= '0;
        end else if (w_cmd_done) begin
            r_tx_sr <= r_rx_sr[6] ? w_rd_data : '0;
        end else if (w_sck_fall && w_tx_act && r_cnt >= CNT_W'(9)) begin
            r_tx_sr <= {r_tx_sr[FTW_W-2:0], 1'b0};
        end
    end

    assign MISO = ~SSEL & w_tx_act & r_tx_sr[FTW_W-1];
`else
    logic w_unused_id;

    assign w_unused_id = ^ID_VALUE;
    assign MISO        = 1'b0;
`endif

    assign dds_data  = r_dds_data;
    assign dds_we    = r_dds_we;
    assign out_en    = r_out_en;
    assign frame_err = r_err;

endmodule

// File: tb/tb_spi_dds_ctrl.sv
// Directed plus randomized SPI frames against spi_dds_ctrl, checked by a register-level model.
// Read data is checked against the model only when SPI_READBACK_EN is defined.
module tb_spi_dds_ctrl;

    localparam logic [47:0] FTW_RST = 48'h0000218DEF41;
    localparam logic [47:0] ID      = 48'h00000E7C0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        mosi;
    logic        ssel;
    logic        miso;
    logic [47:0] dds_data;
    logic        dds_we;
    logic        out_en;
    logic        frame_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_dds_ctrl #(
        .FTW_W    (48),
        .FTW_RESET(FTW_RST),
        .ID_VALUE (ID)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SCK      (sck),
        .MOSI     (mosi),
        .SSEL     (ssel),
        .MISO     (miso),
        .dds_data (dds_data),
        .dds_we   (dds_we),
        .out_en   (out_en),
        .frame_err(frame_err)
    );

    // dds_we pulse monitor
    int          we_cnt    = 0;
    int          we_dbl    = 0;
    int          chg_no_we = 0;
    logic        prev_we   = 1'b0;
    logic [47:0] prev_data = FTW_RST;
    logic [47:0] last_we_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we   <= 1'b0;
            prev_data <= dds_data;
        end else begin
            if (dds_we) begin
                we_cnt       <= we_cnt + 1;
                last_we_data <= dds_data;
                if (prev_we) we_dbl <= we_dbl + 1;
            end else if (dds_data !== prev_data) begin
                chg_no_we <= chg_no_we + 1;
            end
            prev_we   <= dds_we;
            prev_data <= dds_data;
        end
    end

    // Register-level reference model
    logic [47:0] m_stage, m_dds;
    logic        m_out_en, m_auto, m_err;
    int          m_we;

    function automatic void m_reset();
        m_stage  = FTW_RST;
        m_dds    = FTW_RST;
        m_out_en = 1'b0;
        m_auto   = 1'b0;
        m_err    = 1'b0;
    endfunction

    function automatic void m_write(input logic [1:0] a, input logic [47:0] d);
        case (a)
            2'd0: begin
                m_stage = d;
                if (m_auto) begin
                    m_dds = d;
                    m_we++;
                end
            end
            2'd1: begin
                m_out_en = d[0];
                m_auto   = d[1];
                if (d[7]) m_err = 1'b0;
            end
            2'd2: begin
                m_dds = m_stage;
                m_we++;
            end
            default: m_err = 1'b1;
        endcase
    endfunction

    function automatic logic [47:0] m_read(input logic [1:0] a);
`ifdef SPI_READBACK_EN
        case (a)
            2'd0:    return m_stage;
            2'd1:    return {46'd0, m_auto, m_out_en};
            2'd2:    return 48'd0;
            default: return ID;
        endcase
`else
        return (a == 2'd3) ? 48'd0 : 48'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/dds_data"}, 64'(dds_data), 64'(m_dds));
        chk({tag, "/out_en"}, 64'(out_en), 64'(m_out_en));
        chk({tag, "/frame_err"}, 64'(frame_err), 64'(m_err));
        chk({tag, "/we_cnt"}, 64'(we_cnt), 64'(m_we));
        chk({tag, "/we_width"}, 64'(we_dbl), 64'd0);
        chk({tag, "/data_chg_no_we"}, 64'(chg_no_we), 64'd0);
    endtask

    // Mode-0 bit-bang master, SCK = clk/10; MISO sampled just before each rising edge.
    task automatic spi(input logic [7:0] cmd, input logic [47:0] data, input int first,
                       input int last, input bit start, input bit stop, input int gap,
                       output logic [47:0] rd);
        logic [63:0] fv;
        fv = {cmd, data, 8'($urandom)};
        rd = '0;
        if (start) begin
            ssel = 1'b0;
            repeat (5) @(negedge clk);
        end
        for (int i = first; i < last; i++) begin
            mosi = fv[63-i];
            repeat (5) @(negedge clk);
            if (i >= 8 && i < 56) rd = {rd[46:0], miso};
            sck = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
        end
        if (stop) begin
            repeat (5) @(negedge clk);
            ssel = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic frame(input bit rd, input logic [1:0] a, input logic [47:0] d,
                         input int nbits, input int gap, output logic [47:0] rdata);
        spi({rd, 5'($urandom), a}, d, 0, nbits, 1'b1, 1'b1, gap, rdata);
        if (nbits >= 56) begin
            if (!rd) m_write(a, d);
        end else begin
            m_err = 1'b1;
        end
    endtask

    logic [47:0] rdata, exp_rd, d;
    logic [1:0]  a;
    bit          rnw;

    initial begin
        rst_n = 1'b0;
        ssel  = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        m_we  = 0;
        m_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset/dds_data", 64'(dds_data), 64'(FTW_RST));
        chk("reset/dds_we", 64'(dds_we), 64'd0);
        chk("reset/out_en", 64'(out_en), 64'd0);
        chk("reset/miso", 64'(miso), 64'd0);
        chk("reset/frame_err", 64'(frame_err), 64'd0);

        // Stage then commit
        frame(1'b0, 2'd0, 48'h000012345678, 56, 8, rdata);
        chk("stage/no_we", 64'(we_cnt), 64'd0);
        chk("stage/dds_unchanged", 64'(dds_data), 64'(FTW_RST));
        frame(1'b0, 2'd2, 48'hFFFF_FFFF_FFFF, 56, 8, rdata);
        chk("commit/dds_data", 64'(dds_data), 64'h000012345678);
        chk("commit/we_cnt", 64'(we_cnt), 64'd1);
        chk_all("commit");

        // Auto-commit
        frame(1'b0, 2'd1, 48'h3, 56, 8, rdata);
        chk("ctrl/out_en", 64'(out_en), 64'd1);
        chk("ctrl/no_we", 64'(we_cnt), 64'd1);
        frame(1'b0, 2'd0, 48'h0000AABBCCDD, 56, 8, rdata);
        chk("auto/we_cnt", 64'(we_cnt), 64'd2);
        chk("auto/we_data", 64'(last_we_data), 64'h0000AABBCCDD);
        chk_all("auto");

        // Mid-cycle asynchronous reset
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset/dds_data", 64'(dds_data), 64'(FTW_RST));
        chk("areset/dds_we", 64'(dds_we), 64'd0);
        chk("areset/out_en", 64'(out_en), 64'd0);
        chk("areset/miso", 64'(miso), 64'd0);
        chk("areset/frame_err", 64'(frame_err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        repeat (4) @(negedge clk);

        // Aborted frame after 30 bits
        frame(1'b0, 2'd0, 48'h5555_AAAA_5555, 30, 8, rdata);
        chk("abort/frame_err", 64'(frame_err), 64'd1);
        chk_all("abort");
`ifdef SPI_READBACK_EN
        frame(1'b1, 2'd0, 48'd0, 56, 8, rdata);
        chk("abort/stage_readback", 64'(rdata), 64'(FTW_RST));
`endif
        frame(1'b0, 2'd1, 48'h80, 56, 8, rdata);
        chk("w1c/frame_err", 64'(frame_err), 64'd0);
        frame(1'b0, 2'd2, 48'd0, 56, 8, rdata);
        chk("abort/commit_stage", 64'(dds_data), 64'(FTW_RST));
        chk_all("w1c");

        // ID read
        frame(1'b1, 2'd3, 48'hFFFF_FFFF_FFFF, 56, 8, rdata);
`ifdef SPI_READBACK_EN
        chk("id/readback", 64'(rdata), 64'(ID));
`else
        chk("id/miso_zero", 64'(rdata), 64'd0);
`endif
        chk_all("id");

        // Back-to-back frames, 4 clk gap, second with 8 extra SCK bits
        frame(1'b0, 2'd1, 48'h2, 56, 8, rdata);
        frame(1'b0, 2'd0, 48'h0123_4567_89AB, 56, 4, rdata);
        frame(1'b0, 2'd0, 48'hFEDC_BA98_7654, 64, 8, rdata);
        chk("b2b/we_cnt", 64'(we_cnt), 64'(m_we));
        chk("b2b/dds_data", 64'(dds_data), 64'hFEDC_BA98_7654);
        chk("b2b/frame_err", 64'(frame_err), 64'd0);

        // Reset in the middle of a commit frame; the tail must be ignored
        spi(8'h02, 48'd0, 0, 20, 1'b1, 1'b0, 0, rdata);
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        spi(8'h02, 48'd0, 20, 56, 1'b0, 1'b1, 8, rdata);
        chk("midrst/dds_data", 64'(dds_data), 64'(FTW_RST));
        chk_all("midrst");

        // Randomized frames
        for (int n = 0; n < 14; n++) begin
            rnw    = 1'($urandom_range(0, 1));
            a      = 2'($urandom_range(0, 3));
            d      = 48'({$urandom, $urandom});
            exp_rd = m_read(a);
            frame(rnw, a, d, 56, 8, rdata);
            if (rnw) chk($sformatf("rand%0d/read", n), 64'(rdata), 64'(exp_rd));
            chk_all($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
